fetch_pc_queue: RTL and testbench
=================================

FETCH_PC_QUEUE -- requirements
Module: fetch_pc_queue

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4, fetch-queue entries (power of two)
- ID_BITS, 6, branch-ID width
- RESET_PC, 32'h0, first fetch address
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- OUT_pcValid  out  1  fetch request valid this cycle
- OUT_pc  out  32  fetch address, bit 0 always 0
- IN_branchFound  in  1  predictor hit in the current 8-byte block
- IN_branchTaken  in  1  predicted taken
- IN_branchSrc  in  32  predicted branch address
- IN_branchDst  in  32  predicted target
- IN_branchID  in  ID_BITS  predictor entry index
- IN_branchCompr  in  1  predicted branch is 16-bit
- IN_redirValid  in  1  mispredict/exception redirect
- IN_redirPc  in  32  redirect address
- IN_deqReady  in  1  decode accepts the head entry
- OUT_deqValid  out  1  head entry valid
- OUT_deqPc  out  32  fetch address of the head entry
- OUT_deqEndHalf  out  2  last valid halfword index in the block
- OUT_deqBranchID  out  ID_BITS  predictor ID; all-ones if none
- OUT_deqPredTaken  out  1  block ended by a predicted-taken branch
- OUT_deqCompr  out  1  ending branch is compressed

Function
REQ-003 OUT_pcValid SHALL equal !rst && (count != DEPTH); OUT_pc SHALL be the PC register, combinationally.
REQ-004 The predictor inputs SHALL be sampled in the same cycle as OUT_pcValid; the lookup is zero-latency.
REQ-005 A push SHALL occur on a clock edge when OUT_pcValid && !IN_redirValid.
REQ-006 Each pushed entry SHALL hold:
- pc = OUT_pc
- endHalf = IN_branchSrc[2:1] if taken, else 2'b11
- branchID = IN_branchID if found, else all-ones
- predTaken = found && taken
- compr = found ? IN_branchCompr : 0
REQ-007 On a push, the next PC SHALL be IN_branchDst (bit 0 cleared) if predTaken, else {OUT_pc[31:3]+1, 3'b000}; 32-bit wrap-around is permitted.
REQ-008 With no push and no redirect, the PC SHALL hold its value.
REQ-009 A pop SHALL occur when OUT_deqValid && IN_deqReady && !IN_redirValid; OUT_deqValid SHALL equal (count != 0).
REQ-010 A push and a pop in the same cycle SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-011 IN_redirValid SHALL take priority over all other events:
- pc <= {IN_redirPc[31:1], 1'b0}
- count and pointers cleared
- no push or pop that cycle
- fetch resumes at the redirect PC on the next cycle
REQ-012 Head outputs SHALL be registered storage read by the read pointer, with no combinational path from the predictor inputs.

Reset
REQ-013 While rst is high:
- pc <= RESET_PC
- count, read pointer and write pointer <= 0
- OUT_pcValid = 0
REQ-014 rst SHALL override IN_redirValid and discard any in-flight entries; OUT_deqValid SHALL be 0 in the cycle after reset.

Configuration
REQ-015 Macro FETCH_BRANCH_PRED_EN:
- Defined: predictor inputs are used as specified in REQ-006 and REQ-007.
- Undefined: predictor inputs are ignored; every entry gets endHalf=2'b11, branchID all-ones, predTaken=0, compr=0; the next PC is always sequential.

Verification
REQ-016 Reset, then no predictor hit and IN_deqReady=0 -> pushes at 0x0, 0x8, 0x10, 0x18; OUT_pcValid=0 in cycle 5 with count=4.
REQ-017 At pc 0x100, found=1, taken=1, src=0x104, dst=0x200, ID=5, compr=1 -> entry {0x100, endHalf 2, ID 5, taken 1, compr 1}; next OUT_pc = 0x200.
REQ-018 Queue full with IN_deqReady=1 for one cycle -> one pop, count=3, OUT_pcValid=1 in the following cycle.
REQ-019 Queue holding 3 entries; IN_redirValid=1 with IN_redirPc=0x4002 and IN_deqReady=1 -> no pop, count=0, next OUT_pc = 0x4002, OUT_deqValid=0 in the next cycle.
REQ-020 pc=0xFFFFFFF8 with no hit -> next OUT_pc = 0x00000000.
REQ-021 FETCH_BRANCH_PRED_EN undefined, same stimulus as REQ-017 -> entry {0x100, 3, all-ones, 0, 0}; next OUT_pc = 0x108.

Source files
------------

// File: rtl/fetch_pc_queue_if.sv
// rtl/fetch_pc_queue_if.sv - fetch PC queue handshake bundle (predictor, redirect, decode dequeue)
interface fetch_pc_queue_if #(
   parameter int ID_BITS = 6
);
   logic               OUT_pcValid;
   logic [31:0]        OUT_pc;
   logic               IN_branchFound;
   logic               IN_branchTaken;
   logic [31:0]        IN_branchSrc;
   logic [31:0]        IN_branchDst;
   logic [ID_BITS-1:0] IN_branchID;
   logic               IN_branchCompr;
   logic               IN_redirValid;
   logic [31:0]        IN_redirPc;
   logic               IN_deqReady;
   logic               OUT_deqValid;
   logic [31:0]        OUT_deqPc;
   logic [1:0]         OUT_deqEndHalf;
   logic [ID_BITS-1:0] OUT_deqBranchID;
   logic               OUT_deqPredTaken;
   logic               OUT_deqCompr;

   // The queue itself drives the OUT_ side
   modport master (
      output OUT_pcValid, OUT_pc, OUT_deqValid, OUT_deqPc, OUT_deqEndHalf,
             OUT_deqBranchID, OUT_deqPredTaken, OUT_deqCompr,
      input  IN_branchFound, IN_branchTaken, IN_branchSrc, IN_branchDst,
             IN_branchID, IN_branchCompr, IN_redirValid, IN_redirPc, IN_deqReady
   );

   // Predictor, redirect source and decode stage drive the IN_ side
   modport slave (
      input  OUT_pcValid, OUT_pc, OUT_deqValid, OUT_deqPc, OUT_deqEndHalf,
             OUT_deqBranchID, OUT_deqPredTaken, OUT_deqCompr,
      output IN_branchFound, IN_branchTaken, IN_branchSrc, IN_branchDst,
             IN_branchID, IN_branchCompr, IN_redirValid, IN_redirPc, IN_deqReady
   );
endinterface

// File: rtl/fetch_pc_queue.sv
// rtl/fetch_pc_queue.sv - fetch PC generator feeding a small block queue; predictor use gated by FETCH_BRANCH_PRED_EN
module fetch_pc_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ID_BITS  = 6,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic            clk,
   input logic            rst,
   fetch_pc_queue_if.master bus
);
   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = $clog2(DEPTH + 1);
   localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

   logic [31:0]         pc;
   logic [PTR_BITS-1:0] rdPtr;
   logic [PTR_BITS-1:0] wrPtr;
   logic [CNT_BITS-1:0] count;

   logic [31:0]         pcMem      [DEPTH];
   logic [1:0]          endHalfMem [DEPTH];
   logic [ID_BITS-1:0]  idMem      [DEPTH];
   logic [DEPTH-1:0]    takenMem;
   logic [DEPTH-1:0]    comprMem;

   logic                push;
   logic                pop;
   logic [31:0]         seqPc;
   logic [31:0]         nextPc;
   logic [1:0]          newEndHalf;
   logic [ID_BITS-1:0]  newId;
   logic                newTaken;
   logic                newCompr;

   assign bus.OUT_pcValid  = !rst && (count != FULL);
   assign bus.OUT_pc       = pc;
   assign bus.OUT_deqValid = (count != '0);

   // A redirect squashes both ends of the queue in the cycle it arrives
   assign push  = bus.OUT_pcValid && !bus.IN_redirValid;
   assign pop   = bus.OUT_deqValid && bus.IN_deqReady && !bus.IN_redirValid;
   assign seqPc = {pc[31:3] + 29'd1, 3'b000};

   // Head fields come straight from storage, never from the predictor inputs
   assign bus.OUT_deqPc        = pcMem[rdPtr];
   assign bus.OUT_deqEndHalf   = endHalfMem[rdPtr];
   assign bus.OUT_deqBranchID  = idMem[rdPtr];
   assign bus.OUT_deqPredTaken = takenMem[rdPtr];
   assign bus.OUT_deqCompr     = comprMem[rdPtr];

   // Describe the block being fetched now and pick where fetch goes next
   always_comb begin
`ifdef FETCH_BRANCH_PRED_EN
      newTaken   = bus.IN_branchFound && bus.IN_branchTaken;
      newEndHalf = newTaken ? bus.IN_branchSrc[2:1] : 2'b11;
      newId      = bus.IN_branchFound ? bus.IN_branchID : '1;
      newCompr   = bus.IN_branchFound && bus.IN_branchCompr;
      nextPc     = newTaken ? {bus.IN_branchDst[31:1], 1'b0} : seqPc;
`else
      newTaken   = 1'b0;
      newEndHalf = 2'b11;
      newId      = '1;
      newCompr   = 1'b0;
      nextPc     = seqPc;
`endif
   end

   // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else if (bus.IN_redirValid) begin
         pc    <= {bus.IN_redirPc[31:1], 1'b0};
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         if (push) begin
            pc    <= nextPc;
            wrPtr <= wrPtr + PTR_BITS'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_BITS'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_BITS'(1);
         end else if (!push && pop) begin
            count <= count - CNT_BITS'(1);
         end
      end
   end

   // Capture the pushed block; storage is left unreset because count gates its visibility
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr]      <= pc;
         endHalfMem[wrPtr] <= newEndHalf;
         idMem[wrPtr]      <= newId;
         takenMem[wrPtr]   <= newTaken;
         comprMem[wrPtr]   <= newCompr;
      end
   end
endmodule

// File: tb/tb_fetch_pc_queue.sv
// tb/tb_fetch_pc_queue.sv - directed and randomized bench for fetch_pc_queue against a queue-based model
module tb_fetch_pc_queue;
   localparam int          DEPTH    = 4;
   localparam int          ID_BITS  = 6;
   localparam logic [31:0] RESET_PC = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  endHalf;
      logic [5:0]  id;
      logic        taken;
      logic        compr;
   } entry_t;

   logic clk = 1'b0;
   logic rst;
   int   assertCount = 0;
   int   failCount   = 0;

   entry_t      modelQ[$];
   logic [31:0] modelPc;

   fetch_pc_queue_if #(.ID_BITS(ID_BITS)) bus ();

   fetch_pc_queue #(
      .DEPTH   (DEPTH),
      .ID_BITS (ID_BITS),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setIdle();
      bus.IN_branchFound = 1'b0;
      bus.IN_branchTaken = 1'b0;
      bus.IN_branchSrc   = 32'h0;
      bus.IN_branchDst   = 32'h0;
      bus.IN_branchID    = '0;
      bus.IN_branchCompr = 1'b0;
      bus.IN_redirValid  = 1'b0;
      bus.IN_redirPc     = 32'h0;
      bus.IN_deqReady    = 1'b0;
   endtask

   task automatic compareOutputs();
      checkVal("pcValid", bus.OUT_pcValid, !rst && (modelQ.size() != DEPTH));
      if (!rst) begin
         checkVal("pc", bus.OUT_pc, modelPc);
         checkVal("deqValid", bus.OUT_deqValid, modelQ.size() != 0);
         if (modelQ.size() != 0) begin
            checkVal("deqPc", bus.OUT_deqPc, modelQ[0].pc);
            checkVal("deqEndHalf", bus.OUT_deqEndHalf, modelQ[0].endHalf);
            checkVal("deqBranchID", bus.OUT_deqBranchID, modelQ[0].id);
            checkVal("deqPredTaken", bus.OUT_deqPredTaken, modelQ[0].taken);
            checkVal("deqCompr", bus.OUT_deqCompr, modelQ[0].compr);
         end
      end
   endtask

   task automatic updateModel();
      entry_t e;
      logic   hit;
      logic   tk;
      bit     doPop;
      if (rst) begin
         modelPc = RESET_PC;
         modelQ.delete();
      end else if (bus.IN_redirValid) begin
         modelPc = bus.IN_redirPc & 32'hFFFF_FFFE;
         modelQ.delete();
      end else begin
         doPop = (modelQ.size() != 0) && bus.IN_deqReady;
         if (modelQ.size() != DEPTH) begin
`ifdef FETCH_BRANCH_PRED_EN
            hit = bus.IN_branchFound;
            tk  = bus.IN_branchFound && bus.IN_branchTaken;
`else
            hit = 1'b0;
            tk  = 1'b0;
`endif
            e.pc      = modelPc;
            e.endHalf = tk ? bus.IN_branchSrc[2:1] : 2'd3;
            e.id      = hit ? bus.IN_branchID : 6'h3F;
            e.taken   = tk;
            e.compr   = hit && bus.IN_branchCompr;
            modelQ.push_back(e);
            modelPc = tk ? (bus.IN_branchDst & 32'hFFFF_FFFE) : ((modelPc & 32'hFFFF_FFF8) + 32'd8);
         end
         if (doPop) begin
            void'(modelQ.pop_front());
         end
      end
   endtask

   // Inputs are applied just after a falling edge; this settles, checks, models and clocks once
   task automatic step();
      #1;
      compareOutputs();
      updateModel();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      modelPc = RESET_PC;
      rst = 1'b1;
      setIdle();
      step();
      step();
      rst = 1'b0;

      // Sequential fill from reset with decode stalled
      for (int i = 0; i < DEPTH; i++) begin
         #1 checkVal("fillPc", bus.OUT_pc, 32'(i * 8));
         step();
      end
      #1 checkVal("fullPcValid", bus.OUT_pcValid, 1'b0);
      checkVal("fullHeadPc", bus.OUT_deqPc, 32'h0);

      // One pop from a full queue reopens fetch
      bus.IN_deqReady = 1'b1;
      step();
      bus.IN_deqReady = 1'b0;
      #1 checkVal("afterPopPcValid", bus.OUT_pcValid, 1'b1);
      checkVal("afterPopHead", bus.OUT_deqPc, 32'h8);
      step();
      step();
      bus.IN_deqReady = 1'b1;
      step();

      // Redirect beats a ready decode stage
      bus.IN_redirValid = 1'b1;
      bus.IN_redirPc    = 32'h4002;
      step();
      setIdle();
      #1 checkVal("redirDeqValid", bus.OUT_deqValid, 1'b0);
      checkVal("redirPc", bus.OUT_pc, 32'h4002);

      // Sequential step across the top of the address space
      bus.IN_redirValid = 1'b1;
      bus.IN_redirPc    = 32'hFFFF_FFF8;
      step();
      setIdle();
      step();
      #1 checkVal("wrapPc", bus.OUT_pc, 32'h0);

      // Predicted-taken compressed branch at 0x100
      bus.IN_redirValid = 1'b1;
      bus.IN_redirPc    = 32'h100;
      step();
      setIdle();
      bus.IN_branchFound = 1'b1;
      bus.IN_branchTaken = 1'b1;
      bus.IN_branchSrc   = 32'h104;
      bus.IN_branchDst   = 32'h200;
      bus.IN_branchID    = 6'd5;
      bus.IN_branchCompr = 1'b1;
      step();
      setIdle();
      #1 checkVal("brHeadPc", bus.OUT_deqPc, 32'h100);
`ifdef FETCH_BRANCH_PRED_EN
      checkVal("brEndHalf", bus.OUT_deqEndHalf, 2'd2);
      checkVal("brId", bus.OUT_deqBranchID, 6'd5);
      checkVal("brTaken", bus.OUT_deqPredTaken, 1'b1);
      checkVal("brCompr", bus.OUT_deqCompr, 1'b1);
      checkVal("brNextPc", bus.OUT_pc, 32'h200);
`else
      checkVal("brEndHalf", bus.OUT_deqEndHalf, 2'd3);
      checkVal("brId", bus.OUT_deqBranchID, 6'h3F);
      checkVal("brTaken", bus.OUT_deqPredTaken, 1'b0);
      checkVal("brCompr", bus.OUT_deqCompr, 1'b0);
      checkVal("brNextPc", bus.OUT_pc, 32'h108);
`endif

      // Randomized traffic with occasional redirects and resets
      for (int n = 0; n < 2000; n++) begin
         rst                = ($urandom_range(99) == 0);
         bus.IN_branchFound = $urandom_range(1);
         bus.IN_branchTaken = bus.IN_branchFound ? 1'($urandom_range(1)) : 1'b0;
         bus.IN_branchSrc   = $urandom;
         bus.IN_branchDst   = $urandom;
         bus.IN_branchID    = ID_BITS'($urandom);
         bus.IN_branchCompr = $urandom_range(1);
         bus.IN_redirValid  = ($urandom_range(19) == 0);
         bus.IN_redirPc     = $urandom;
         bus.IN_deqReady    = ($urandom_range(2) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
